// File: rtl/and_arbiter.sv
// Round-robin arbiter in front of a shared bitwise-AND unit.
// One operation per three cycles: IDLE (arbitrate) -> GRANT -> DONE.
module and_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       res,
    output logic                   res_valid,
    output logic [1:0]             res_id,
    output logic                   busy
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] win_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;

    logic [N_REQ-1:0] gnt_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             res_valid_nxt;
    logic [1:0]       res_id_nxt;
    logic             busy_nxt;

    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win_c;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // Round-robin search starting at ptr; index arithmetic wraps modulo 4.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        win_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win_c = idx;
            end
        end
    end

    // Operand mux for the winner.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (win_c == IDX_W'(j)) begin
                a_sel = op_a[j*WIDTH +: WIDTH];
                b_sel = op_b[j*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        win_nxt       = win;
        a_nxt         = a_q;
        b_nxt         = b_q;
        gnt_nxt       = '0;
        res_nxt       = res;
        res_valid_nxt = 1'b0;
        res_id_nxt    = res_id;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    ptr_nxt   = win_c + IDX_W'(1);
                    win_nxt   = win_c;
                    a_nxt     = a_sel;
                    b_nxt     = b_sel;
                    gnt_nxt   = N_REQ'(1) << win_c;
                end
            end
            GRANT: begin
                state_nxt     = DONE;
                res_nxt       = a_q & b_q;
                res_valid_nxt = 1'b1;
                res_id_nxt    = win;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            gnt       <= gnt_nxt;
            res       <= res_nxt;
            res_valid <= res_valid_nxt;
            res_id    <= res_id_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_and_arbiter.sv
// Scoreboard bench for and_arbiter: an edge-level model predicts grant and
// result events; a negedge monitor compares everything the DUT shows.
module tb_and_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        int         stamp;
        logic [3:0] g;
        logic [7:0] r;
        logic [1:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  gnt;
    logic [7:0]  res;
    logic        res_valid;
    logic [1:0]  res_id;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    exp_t gq[$];
    exp_t rq[$];
    int   edge_n   = 0;
    int   rst_edge = -1;
    int   busy_lo  = 1;
    int   busy_hi  = 0;
    int   next_ok  = 0;
    int   ptr_m    = 0;

    and_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res       (res),
        .res_valid (res_valid),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Model of one rising edge: arbitrate when free, predict gnt and result.
    task automatic model_edge();
        int   win;
        exp_t e;
        if (rst) begin
            ptr_m    = 0;
            next_ok  = edge_n + 1;
            rst_edge = edge_n;
            busy_hi  = edge_n - 1;
            while (gq.size() > 0 && gq[$].stamp >= edge_n) void'(gq.pop_back());
            while (rq.size() > 0 && rq[$].stamp >= edge_n) void'(rq.pop_back());
        end else if (edge_n >= next_ok && req != 4'b0) begin
            win = -1;
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && req[(ptr_m + k) % 4]) win = (ptr_m + k) % 4;
            end
            e.stamp = edge_n;
            e.g     = 4'(1 << win);
            e.r     = op_a[win*8 +: 8] & op_b[win*8 +: 8];
            e.id    = 2'(win);
            gq.push_back(e);
            e.stamp = edge_n + 1;
            rq.push_back(e);
            ptr_m   = (win + 1) % 4;
            next_ok = edge_n + 3;
            busy_lo = edge_n;
            busy_hi = edge_n + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    // Monitor: compares DUT outputs mid-cycle against scoreboard expectations.
    logic [7:0] hold_res = 8'h0;
    logic [1:0] hold_id  = 2'h0;
    initial begin
        logic [3:0] exp_g;
        logic       exp_v;
        forever begin
            @(negedge clk);
            if (rst_edge == edge_n) begin
                hold_res = 8'h0;
                hold_id  = 2'h0;
            end
            exp_g = 4'b0;
            if (gq.size() > 0 && gq[0].stamp == edge_n) begin
                exp_g = gq[0].g;
                void'(gq.pop_front());
            end
            exp_v = 1'b0;
            if (rq.size() > 0 && rq[0].stamp == edge_n) begin
                exp_v    = 1'b1;
                hold_res = rq[0].r;
                hold_id  = rq[0].id;
                void'(rq.pop_front());
            end
            check("gnt", 32'(gnt), 32'(exp_g));
            check("res_valid", 32'(res_valid), 32'(exp_v));
            check("res", 32'(res), 32'(hold_res));
            check("res_id", 32'(res_id), 32'(hold_id));
            check("busy", 32'(busy), 32'(edge_n >= busy_lo && edge_n <= busy_hi));
        end
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        op_a = 32'h0;
        op_b = 32'h0;

        // Reset held two cycles with all requests high, then rotation.
        tick();
        tick();
        rst  = 1'b0;
        op_a = 32'h1234_5678;
        op_b = 32'hFFFF_0F0F;
        for (int i = 0; i < 16; i++) tick();

        // Single request on requester 2: F0 & 3C.
        rst = 1'b1;
        req = 4'b0;
        tick();
        rst  = 1'b0;
        req  = 4'b0100;
        op_a = 32'h00F0_0000;
        op_b = 32'h003C_0000;
        tick();
        req = 4'b0;
        tick();
        tick();

        // ptr now 3: wrap to 0, then skip to 1 with req held.
        req  = 4'b0011;
        op_a = 32'hAAAA_5A5A;
        op_b = 32'h0F0F_FFFF;
        for (int i = 0; i < 7; i++) tick();
        req = 4'b0;
        tick();
        tick();

        // Operand change during GRANT, new request raised during DONE.
        req  = 4'b0100;
        op_a = 32'h00C3_0000;
        op_b = 32'h00FF_0000;
        tick();
        req  = 4'b0;
        op_a = 32'h0011_0000;
        tick();
        req  = 4'b1000;
        op_a = 32'h7700_0000;
        op_b = 32'h3F00_0000;
        tick();
        for (int i = 0; i < 3; i++) tick();
        req = 4'b0;
        tick();
        tick();

        // Reset during GRANT aborts; next search restarts at index 0.
        req = 4'b0100;
        tick();
        rst = 1'b1;
        req = 4'b0;
        tick();
        rst  = 1'b0;
        req  = 4'b1001;
        op_a = 32'hF0F0_F0F0;
        op_b = 32'h0FFF_FF0F;
        tick();
        req = 4'b0;
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            req  = 4'($urandom_range(0, 15));
            op_a = $urandom;
            op_b = $urandom;
            tick();
        end

        rst = 1'b0;
        req = 4'b0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("gnt_queue_drained", 32'(gq.size()), 32'd0);
        check("res_queue_drained", 32'(rq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
